// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-channel round-robin arbiter.
package rr_arb_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] idx_t;

  // Round-robin successor of a grant index; wraps 3 -> 0.
  function automatic idx_t rr_next(input idx_t g);
    return idx_t'(g + 2'd1);
  endfunction

endpackage

// File: rtl/mux_case_4x1.sv
// Purely combinational 4:1 word select driven by a 2-bit index.
module mux_case_4x1 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out
);

  // Select one of the four channel words.
  always_comb begin
    out = in0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/rr_arb_4x1.sv
// Four-channel round-robin arbiter feeding a single registered output slot.
// The search starts at ptr, which moves one past the last winner so every
// requesting channel is served within four transfers.
module rr_arb_4x1
  import rr_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SEL_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          in_valid,
  output logic [3:0]          in_ready,
  input  logic [WIDTH-1:0]    in0,
  input  logic [WIDTH-1:0]    in1,
  input  logic [WIDTH-1:0]    in2,
  input  logic [WIDTH-1:0]    in3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [SEL_BITS-1:0] out_sel
);

  idx_t             ptr;
  idx_t             grant;
  idx_t             cand;
  logic             found;
  logic             load_en;
  logic [WIDTH-1:0] mux_out;

  // Grant search from ptr upward and per-channel ready generation.
  always_comb begin
    load_en  = !out_valid || out_ready;
    grant    = ptr;
    cand     = ptr;
    found    = 1'b0;
    in_ready = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = idx_t'(ptr + idx_t'(k));
      if (!found && in_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
    // rst_n gating keeps ready low for the whole reset window even though
    // the cleared output slot would otherwise allow a load.
    if (rst_n && load_en && found) begin
      in_ready[grant] = 1'b1;
    end
  end

  mux_case_4x1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel(grant),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .out(mux_out)
  );

  // Output slot and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (found) begin
        out_data  <= mux_out;
        out_sel   <= SEL_BITS'(grant);
        out_valid <= 1'b1;
        ptr       <= rr_next(grant);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_4x1.sv
// Directed bench for rr_arb_4x1 with hand-computed expectations.
module tb_rr_arb_4x1;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [7:0] in0, in1, in2, in3;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_sel;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arb_4x1 #(
    .WIDTH(8),
    .SEL_BITS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sel(out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
    chk({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    // Reset held with every channel requesting: nothing may be taken.
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in0 = 8'h10; in1 = 8'h21; in2 = 8'h32; in3 = 8'h43;
    #12;
    chk_out("reset", 1'b0, 2'd0, 8'h00);
    chk("reset.in_ready", 32'(in_ready), 32'h0);

    // Full load, downstream always ready: 0,1,2,3,0 with no bubbles.
    rst_n = 1'b1;
    #1;
    chk("rr.first_ready", 32'(in_ready), 32'b0001);
    step(); chk_out("rr0", 1'b1, 2'd0, 8'h10); chk("rr0.in_ready", 32'(in_ready), 32'b0010);
    step(); chk_out("rr1", 1'b1, 2'd1, 8'h21); chk("rr1.in_ready", 32'(in_ready), 32'b0100);
    step(); chk_out("rr2", 1'b1, 2'd2, 8'h32); chk("rr2.in_ready", 32'(in_ready), 32'b1000);
    step(); chk_out("rr3", 1'b1, 2'd3, 8'h43); chk("rr3.in_ready", 32'(in_ready), 32'b0001);
    step(); chk_out("rr4", 1'b1, 2'd0, 8'h10);

    // ptr is now 1; channels 0 and 3 request: 3, then wrap to 0, then 3.
    in_valid = 4'b1001;
    #1;
    chk("wrap.in_ready_a", 32'(in_ready), 32'b1000);
    step(); chk_out("wrap_a", 1'b1, 2'd3, 8'h43); chk("wrap.in_ready_b", 32'(in_ready), 32'b0001);
    step(); chk_out("wrap_b", 1'b1, 2'd0, 8'h10); chk("wrap.in_ready_c", 32'(in_ready), 32'b1000);
    step(); chk_out("wrap_c", 1'b1, 2'd3, 8'h43);

    // Requests vanish: slot empties, word and pointer (0) hold.
    in_valid = 4'b0000;
    #1;
    chk("idle.in_ready", 32'(in_ready), 32'h0);
    step(); chk_out("idle", 1'b0, 2'd3, 8'h43);
    step(); chk_out("idle2", 1'b0, 2'd3, 8'h43);
    in_valid = 4'b1111;
    #1;
    chk("idle.ptr_held", 32'(in_ready), 32'b0001);

    // Backpressure: only channel 2 requests, downstream stalls.
    in_valid  = 4'b0100;
    in2       = 8'hA5;
    out_ready = 1'b0;
    #1;
    chk("bp.load_empty", 32'(in_ready), 32'b0100);
    step(); chk_out("bp.load", 1'b1, 2'd2, 8'hA5);
    chk("bp.ready_low0", 32'(in_ready), 32'h0);
    in2 = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out("bp.hold", 1'b1, 2'd2, 8'hA5);
      chk("bp.ready_low", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'b0100);
    step(); chk_out("bp.next", 1'b1, 2'd2, 8'h5A);

    // Mid-stream reset with a held word: cleared without waiting for a clock.
    in_valid = 4'b1110;
    rst_n    = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 2'd0, 8'h00);
    chk("midrst.in_ready", 32'(in_ready), 32'h0);
    in_valid = 4'b0110;
    rst_n    = 1'b1;
    #1;
    chk("postrst.in_ready", 32'(in_ready), 32'b0010);
    step(); chk_out("postrst", 1'b1, 2'd1, 8'h21);
    step(); chk_out("postrst2", 1'b1, 2'd2, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
